// File: rtl/lifting_dwt_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lifting_dwt_scheduler_if                                             |
// | Frame load, lifting-datapath and coefficient stream signals.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lifting_dwt_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              lift_valid;
    logic [DATA_W-1:0] lift_even;
    logic [DATA_W-1:0] lift_odd;
    logic [DATA_W-1:0] lift_an;
    logic [DATA_W-1:0] lift_dn;
    logic              coef_valid;
    logic [DATA_W-1:0] coef_data;
    logic [3:0]        coef_level;
    logic              coef_detail;
    logic [ADDR_W-1:0] coef_index;
    logic              busy;
    logic              done;

    // master: acquisition front-end + lifting datapath + coefficient sink
    modport master (
        output start, in_valid, in_data, lift_an, lift_dn,
        input  in_ready, lift_valid, lift_even, lift_odd, coef_valid,
               coef_data, coef_level, coef_detail, coef_index, busy, done
    );

    modport slave (
        input  start, in_valid, in_data, lift_an, lift_dn,
        output in_ready, lift_valid, lift_even, lift_odd, coef_valid,
               coef_data, coef_level, coef_detail, coef_index, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/lifting_dwt_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lifting_dwt_scheduler                                                |
// | Buffers a frame and sequences an external lifting stage over LEVELS  |
// | in-place decomposition passes, streaming details then approximations.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lifting_dwt_scheduler #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int FRAME_LEN = 256,
    parameter int LEVELS    = 4,
    parameter int LIFT_LAT  = 3
) (
    input wire clk,
    input wire rst,
    lifting_dwt_scheduler_if.slave bus
);
    localparam int                MEM_AW     = $clog2(FRAME_LEN);
    localparam int                CNT_W      = $clog2(LIFT_LAT + 2);
    localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'((FRAME_LEN >> LEVELS) - 1);
    localparam logic [3:0]        LEVEL_LAST = 4'(LEVELS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RD_EVEN = 3'd2,
        RD_ODD  = 3'd3,
        DRAIN   = 3'd4,
        FLUSH   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FRAME_LEN];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] pair;
    logic [ADDR_W-1:0] lift_idx;
    logic [ADDR_W-1:0] flush_idx;
    logic [3:0]        level;
    logic [CNT_W-1:0]  in_flight;
    logic [LIFT_LAT-1:0] ret_valid;
    logic [ADDR_W-1:0] ret_idx [LIFT_LAT];

    logic              load_acc;
    logic              ret_fire;
    logic              issue;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   half_len;
    logic [ADDR_W-1:0] pair_last;
    logic [ADDR_W-1:0] even_addr;
    logic [ADDR_W-1:0] odd_addr;

    assign load_acc  = (state == LOAD) && bus.in_valid && bus.in_ready;
    assign ret_fire  = ret_valid[LIFT_LAT-1];
    assign issue     = (state == RD_ODD);
    assign half_len  = (ADDR_W+1)'(FRAME_LEN) >> (level + 4'd1);
    assign pair_last = ADDR_W'(half_len - (ADDR_W+1)'(1));
    assign even_addr = {pair[ADDR_W-2:0], 1'b0};
    assign odd_addr  = {pair[ADDR_W-2:0], 1'b1};

    // Load writes and lift write-backs never coincide: no pair is in flight during LOAD.
    assign mem_we    = load_acc || ret_fire;
    assign mem_waddr = load_acc ? wr_ptr : ret_idx[LIFT_LAT-1];
    assign mem_wdata = load_acc ? bus.in_data : bus.lift_an;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr[MEM_AW-1:0]] <= mem_wdata;
        end
    end

    // Return tracker: carries each issued pair index until its datapath result arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_valid <= '0;
            for (int k = 0; k < LIFT_LAT; k++) begin
                ret_idx[k] <= '0;
            end
        end else begin
            ret_valid[0] <= bus.lift_valid;
            ret_idx[0]   <= lift_idx;
            for (int k = 1; k < LIFT_LAT; k++) begin
                ret_valid[k] <= ret_valid[k-1];
                ret_idx[k]   <= ret_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            pair            <= '0;
            lift_idx        <= '0;
            flush_idx       <= '0;
            level           <= '0;
            in_flight       <= '0;
            bus.in_ready    <= 1'b0;
            bus.lift_valid  <= 1'b0;
            bus.lift_even   <= '0;
            bus.lift_odd    <= '0;
            bus.coef_valid  <= 1'b0;
            bus.coef_data   <= '0;
            bus.coef_level  <= '0;
            bus.coef_detail <= 1'b0;
            bus.coef_index  <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.lift_valid <= 1'b0;
            bus.coef_valid <= 1'b0;
            bus.done       <= 1'b0;

            if (ret_fire) begin
                bus.coef_valid  <= 1'b1;
                bus.coef_detail <= 1'b1;
                bus.coef_level  <= level;
                bus.coef_index  <= ret_idx[LIFT_LAT-1];
                bus.coef_data   <= bus.lift_dn;
            end

            if (issue && !ret_fire) begin
                in_flight <= in_flight + CNT_W'(1);
            end else if (!issue && ret_fire) begin
                in_flight <= in_flight - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= LOAD;
                        wr_ptr       <= '0;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_acc) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == LOAD_LAST) begin
                            bus.in_ready <= 1'b0;
                            level        <= '0;
                            pair         <= '0;
                            state        <= RD_EVEN;
                        end
                    end
                end
                RD_EVEN: begin
                    bus.lift_even <= mem[even_addr[MEM_AW-1:0]];
                    state         <= RD_ODD;
                end
                RD_ODD: begin
                    bus.lift_odd   <= mem[odd_addr[MEM_AW-1:0]];
                    bus.lift_valid <= 1'b1;
                    lift_idx       <= pair;
                    if (pair == pair_last) begin
                        pair  <= '0;
                        state <= DRAIN;
                    end else begin
                        pair  <= pair + ADDR_W'(1);
                        state <= RD_EVEN;
                    end
                end
                DRAIN: begin
                    if (in_flight == '0) begin
                        if (level == LEVEL_LAST) begin
                            flush_idx <= '0;
                            state     <= FLUSH;
                        end else begin
                            level <= level + 4'd1;
                            state <= RD_EVEN;
                        end
                    end
                end
                FLUSH: begin
                    bus.coef_valid  <= 1'b1;
                    bus.coef_detail <= 1'b0;
                    bus.coef_level  <= LEVEL_LAST;
                    bus.coef_index  <= flush_idx;
                    bus.coef_data   <= mem[flush_idx[MEM_AW-1:0]];
                    flush_idx       <= flush_idx + ADDR_W'(1);
                    if (flush_idx == FLUSH_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
